// File: rtl/cfa_pkg.sv
// cfa_pkg: shared constants, Bayer phase decode and rounding averages for the demosaic.
// Build macro CFA_EDGE_GREEN_EN selects the edge-directed green variant (one extra stage).
package cfa_pkg;

  localparam int unsigned BAYER_RGGB = 0;
  localparam int unsigned BAYER_GRBG = 1;
  localparam int unsigned BAYER_GBRG = 2;
  localparam int unsigned BAYER_BGGR = 3;

`ifdef CFA_EDGE_GREEN_EN
  localparam int unsigned CFA_LAT = 4;
`else
  localparam int unsigned CFA_LAT = 3;
`endif

  // Colour of a site: R, G on an R row, G on a B row, B.
  typedef enum logic [1:0] {
    SiteR  = 2'd0,
    SiteGr = 2'd1,
    SiteGb = 2'd2,
    SiteB  = 2'd3
  } cfa_site_e;

  // Bit 1 of the phase follows the row parity, bit 0 the column parity.
  function automatic cfa_site_e cfa_phase(input logic [1:0] bayer, input logic yc0,
                                          input logic xc0);
    return cfa_site_e'(bayer ^ {yc0, xc0});
  endfunction

  // Helpers run at 16 bits; callers zero-extend DATA_W (<= 14) samples, so no bits are lost.
  function automatic logic [15:0] avg2(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = 17'(a) + 17'(b) + 17'd1;
    return s[16:1];
  endfunction

  function automatic logic [15:0] avg4(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c, input logic [15:0] d);
    logic [17:0] s;
    s = 18'(a) + 18'(b) + 18'(c) + 18'(d) + 18'd2;
    return s[17:2];
  endfunction

endpackage

// File: rtl/cfa_line_buf.sv
// cfa_line_buf: one raw line of storage, read-before-write at a single address.
module cfa_line_buf
  import cfa_pkg::*;
#(
  parameter int unsigned DataW = 8,
  parameter int unsigned Depth = 512,
  parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] wdata_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [Depth];

  // The read sees the word from the previous line; the new word lands on the clock edge.
  assign rdata_o = mem_q[addr_i];

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/cfa_bilinear3x3.sv
// cfa_bilinear3x3: Bayer-to-RGB bilinear demosaic over a 3x3 window, output is the window centre.
// Build macro CFA_EDGE_GREEN_EN: edge-directed green at R/B sites, adds one pipeline stage.
module cfa_bilinear3x3
  import cfa_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_W  = 512,
  parameter int unsigned BAYER  = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_vsync,
  input  logic              in_hsync,
  input  logic              in_den,
  input  logic [DATA_W-1:0] in_raw,
  output logic              out_vsync,
  output logic              out_hsync,
  output logic              out_den,
  output logic [DATA_W-1:0] out_r,
  output logic [DATA_W-1:0] out_g,
  output logic [DATA_W-1:0] out_b,
  output logic              err_ovf
);

  localparam int unsigned AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int unsigned XW = $clog2(MAX_W + 1);
  localparam logic [1:0] BayerPh = 2'(BAYER);
  localparam logic [XW-1:0] XMax = XW'(MAX_W);

  typedef struct packed {
    logic              vs;
    logic              hs;
    logic              den;
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] b;
  } pix_t;

  logic [XW-1:0]     x_q, x_d;
  logic              y0_q, y0_d, yhi_q, yhi_d, err_q, err_d;
  logic              ovf_x, den_fall, lb_we;
  logic [AW-1:0]     lb_addr;
  logic [DATA_W-1:0] mid_rd, top_rd;
  // S1
  logic              vs1_q, hs1_q, den1_q, mask1_q;
  logic [DATA_W-1:0] raw1_q, mid1_q, top1_q;
  cfa_site_e         ph1_q;
  // S2
  logic              vs2_q, hs2_q, den2_q, mask2_q;
  cfa_site_e         ph2_q;
  logic [DATA_W-1:0] win_q [3][3];
  // S3 and output
  logic [15:0]       c_w, up_w, dn_w, lf_w, rt_w, diag_w, orth_w, lr_w, ud_w;
  pix_t              s3_d, s3_o, out_q;

  assign ovf_x    = (x_q >= XMax);
  assign den_fall = den1_q & ~in_den;
  assign lb_we    = in_den & ~ovf_x;
  // Past MAX_W the address is parked at 0; the pixel is masked anyway.
  assign lb_addr  = ovf_x ? '0 : x_q[AW-1:0];

  // Line y-1 feeds line y-2 on the same cycle, so the window gets both rows above x.
  cfa_line_buf #(.DataW(DATA_W), .Depth(MAX_W), .AddrW(AW)) u_line1 (
    .clk_i  (clk),
    .we_i   (lb_we),
    .addr_i (lb_addr),
    .wdata_i(in_raw),
    .rdata_o(mid_rd)
  );

  cfa_line_buf #(.DataW(DATA_W), .Depth(MAX_W), .AddrW(AW)) u_line2 (
    .clk_i  (clk),
    .we_i   (lb_we),
    .addr_i (lb_addr),
    .wdata_i(mid_rd),
    .rdata_o(top_rd)
  );

  // Column/row counters and the sticky overflow flag; y only needs parity and "y >= 2".
  always_comb begin
    x_d   = x_q;
    y0_d  = y0_q;
    yhi_d = yhi_q;
    err_d = err_q;
    if (in_den) x_d = ovf_x ? x_q : x_q + XW'(1);
    else if (den_fall) x_d = '0;
    if (!in_vsync) begin
      y0_d  = 1'b0;
      yhi_d = 1'b0;
    end else if (den_fall) begin
      y0_d  = ~y0_q;
      yhi_d = yhi_q | y0_q;
    end
    if (in_vsync && !vs1_q) err_d = 1'b0;
    else if (in_den && ovf_x) err_d = 1'b1;
  end

  // Counters and S1: register the input pixel, both line-buffer reads and centre attributes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= '0;
      y0_q    <= 1'b0;
      yhi_q   <= 1'b0;
      err_q   <= 1'b0;
      vs1_q   <= 1'b0;
      hs1_q   <= 1'b0;
      den1_q  <= 1'b0;
      mask1_q <= 1'b1;
      raw1_q  <= '0;
      mid1_q  <= '0;
      top1_q  <= '0;
      ph1_q   <= SiteR;
    end else begin
      x_q     <= x_d;
      y0_q    <= y0_d;
      yhi_q   <= yhi_d;
      err_q   <= err_d;
      vs1_q   <= in_vsync;
      hs1_q   <= in_hsync;
      den1_q  <= in_den;
      mask1_q <= ~in_den | ovf_x | (x_q < XW'(2)) | ~yhi_q;
      raw1_q  <= in_raw;
      mid1_q  <= mid_rd;
      top1_q  <= top_rd;
      // Centre sits at (x-1, y-1), so both parities flip.
      ph1_q   <= cfa_phase(BayerPh, ~y0_q, ~x_q[0]);
    end
  end

  // S2: shift the 3x3 window on valid pixels and carry the centre attributes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs2_q   <= 1'b0;
      hs2_q   <= 1'b0;
      den2_q  <= 1'b0;
      mask2_q <= 1'b1;
      ph2_q   <= SiteR;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
      end
    end else begin
      vs2_q   <= vs1_q;
      hs2_q   <= hs1_q;
      den2_q  <= den1_q;
      mask2_q <= mask1_q;
      ph2_q   <= ph1_q;
      if (den1_q) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= top1_q;
        win_q[1][2] <= mid1_q;
        win_q[2][2] <= raw1_q;
      end
    end
  end

`ifdef CFA_EDGE_GREEN_EN
  logic [15:0] dh_w, dv_w;
`endif

  // S3 arithmetic: per-site interpolation of the centre, zeroed on border/overflow.
  always_comb begin
    c_w    = 16'(win_q[1][1]);
    up_w   = 16'(win_q[0][1]);
    dn_w   = 16'(win_q[2][1]);
    lf_w   = 16'(win_q[1][0]);
    rt_w   = 16'(win_q[1][2]);
    lr_w   = avg2(lf_w, rt_w);
    ud_w   = avg2(up_w, dn_w);
    diag_w = avg4(16'(win_q[0][0]), 16'(win_q[0][2]), 16'(win_q[2][0]), 16'(win_q[2][2]));
    orth_w = avg4(up_w, dn_w, lf_w, rt_w);
`ifdef CFA_EDGE_GREEN_EN
    dh_w = (lf_w > rt_w) ? lf_w - rt_w : rt_w - lf_w;
    dv_w = (up_w > dn_w) ? up_w - dn_w : dn_w - up_w;
    // Interpolate along the direction with the smaller gradient.
    if (dh_w < dv_w) orth_w = lr_w;
    else if (dv_w < dh_w) orth_w = ud_w;
`endif
    s3_d     = '0;
    s3_d.vs  = vs2_q;
    s3_d.hs  = hs2_q;
    s3_d.den = den2_q;
    unique case (ph2_q)
      SiteR: begin
        s3_d.r = DATA_W'(c_w);
        s3_d.g = DATA_W'(orth_w);
        s3_d.b = DATA_W'(diag_w);
      end
      SiteB: begin
        s3_d.r = DATA_W'(diag_w);
        s3_d.g = DATA_W'(orth_w);
        s3_d.b = DATA_W'(c_w);
      end
      SiteGr: begin
        s3_d.r = DATA_W'(lr_w);
        s3_d.g = DATA_W'(c_w);
        s3_d.b = DATA_W'(ud_w);
      end
      SiteGb: begin
        s3_d.r = DATA_W'(ud_w);
        s3_d.g = DATA_W'(c_w);
        s3_d.b = DATA_W'(lr_w);
      end
    endcase
    if (mask2_q) begin
      s3_d.r = '0;
      s3_d.g = '0;
      s3_d.b = '0;
    end
  end

`ifdef CFA_EDGE_GREEN_EN
  pix_t ext_q;
  // Extra stage that pays for the gradient compare.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ext_q <= '0;
    else ext_q <= s3_d;
  end
  assign s3_o = ext_q;
`else
  assign s3_o = s3_d;
`endif

  // Output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_q <= '0;
    else out_q <= s3_o;
  end

  assign out_vsync = out_q.vs;
  assign out_hsync = out_q.hs;
  assign out_den   = out_q.den;
  assign out_r     = out_q.r;
  assign out_g     = out_q.g;
  assign out_b     = out_q.b;
  assign err_ovf   = err_q;

endmodule

// File: doc/cfa_bilinear3x3.md
Name: cfa_bilinear3x3

Overview:
Parametrised Bayer-to-RGB demosaic for the ISP raw path, between raw capture/black-level and colour correction.
Buffers two raw lines, forms a 3x3 window and outputs bilinear-interpolated R/G/B per pixel.
Data width, line length and Bayer phase are generic; sync signals pass through with fixed latency.

Parameters:
DATA_W, 8, raw and per-channel output width (8..14)
MAX_W, 512, maximum pixels per line; sets line-buffer depth
BAYER, 0, pattern of pixel (0,0): 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
in_vsync  in  1  high for the whole frame
in_hsync  in  1  line sync, passed through only
in_den  in  1  pixel valid
in_raw  in  DATA_W  raw Bayer sample
out_vsync  out  1  in_vsync delayed by LAT
out_hsync  out  1  in_hsync delayed by LAT
out_den  out  1  in_den delayed by LAT
out_r  out  DATA_W  red
out_g  out  DATA_W  green
out_b  out  DATA_W  blue
err_ovf  out  1  sticky: line longer than MAX_W in the current frame

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. All outputs are 0. Counters, window and sync pipe are cleared. Line-buffer contents are not cleared.
- Latency LAT=3 cycles, in_* to out_*. Stages: S1 registers input and reads both line buffers (read-before-write at column x). S2 shifts the 3x3 window and decodes colour. S3 does the interpolation arithmetic and registers the outputs.
- Column x: increments on each in_den; clears to 0 on the in_den falling edge.
- Row y: increments on each in_den falling edge; clears while in_vsync=0.
- Window: the current input pixel (x,y) is the bottom-right corner. The output pixel is the centre (x-1,y-1).
- Spatial shift: the output image is shifted by one row and one column. This is intentional and documented for downstream.
- Border: if x<2 or y<2 at the input, RGB is forced to 0 while out_den is still asserted. The last input row and column are never centred.
- Colour of the centre: phase = BAYER xor {yc[0],xc[0]}, where bit1 is the row and bit0 is the column.
- R site: R=centre; G=avg of 4 orthogonal neighbours; B=avg of 4 diagonals.
- B site: mirror of the R site.
- G on an R row: R=avg(left,right); B=avg(up,down).
- G on a B row: R=avg(up,down); B=avg(left,right).
- Arithmetic for 4-term averages: sum in DATA_W+2 bits, add 2, shift right by 2.
- Arithmetic for 2-term averages: sum in DATA_W+1 bits, add 1, shift right by 1.
- No saturation is needed (the result is always ≤ max input).
- Overflow: when x ≥ MAX_W, line-buffer writes are suppressed, RGB outputs are 0 and err_ovf is set. err_ovf clears on the in_vsync rising edge.
- Simultaneous in_vsync fall and in_den: the vsync clear wins, and y=0 for the next frame.
- Reset mid-frame: the output is invalid until the next in_vsync rising edge. No X propagates, because masking is on y<2.

Optional Feature:
Macro: CFA_EDGE_GREEN_EN.
- Enabled: at R/B sites, G is edge-directed.
  - dh=|left-right|, dv=|up-down|.
  - dh<dv: G=avg(left,right). dv<dh: G=avg(up,down). Equal: 4-term average.
  - Adds one pipeline stage, so LAT=4.
- Disabled: plain 4-term average and LAT=3.
- R and B interpolation are identical in both builds.

Decomposition:
- cfa_pkg holds:
  - Bayer pattern constants BAYER_RGGB/GRBG/GBRG/BGGR.
  - The phase-decode function.
  - CFA_LAT, derived from CFA_EDGE_GREEN_EN.
  - The rounding average helpers (avg2, avg4).
- Sub-module cfa_line_buf: single-port read-before-write RAM, depth MAX_W, width DATA_W, with write enable. Instantiated twice and chained as line y-1 → line y-2.

Test Plan:
- Flat field: 8x8 frame, all raw=100, BAYER=0 → every interior out_r/g/b = 100. Rows/cols 0–1 are output as 0. out_den is in_den delayed by exactly 3 cycles.
- Bayer phase: 6x6 frame, R sites=200, G=100, B=50.
  - Run for each of BAYER=0..3 with the matching layout.
  - Every interior pixel must give (200,100,50).
- Rounding: G neighbours 1,1,1,2 at an R site → G=(5+2)>>2=1. Left/right of 254 and 255 → avg2=255.
- Overflow: MAX_W=16, drive a 20-pixel line → err_ovf=1 from pixel 16 onward, RGB=0 there. Next frame with 16-pixel lines → err_ovf clears at the vsync rise.
- Mid-frame reset: assert reset_n low for 2 cycles at row 4 → all outputs are 0 immediately (asynchronous). Next frame output matches the flat-field result.
- CFA_EDGE_GREEN_EN: vertical edge (columns <3 =0, ≥3 =200) → G at R sites on the edge equals avg(up,down), with no 50/150 blend. LAT=4.
